decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Instruction decode stage placed directly downstream of the fetch stage.
- Consumes the fetched 16-bit instruction, its 8-bit PC and the fetch valid flag.
- Splits the instruction into register indices, immediate and control signals, and registers the results into the ID/EX pipeline register.
- Resolves unconditional jumps early, detects load-use hazards, and drives the stall and jump inputs of fetch.

Parameters:
- IW, 16, instruction width
- PCW, 8, PC / address width
- RIW, 4, register index width
- CNTW, 16, width of the saturating performance counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr_in  in  16  instruction from fetch
- pc_in  in  8  PC of instr_in
- valid_in  in  1  instr_in is valid
- flush_in  in  1  taken branch resolved in EX; kill the instruction in decode
- stall  out  1  hold fetch (combinational)
- jump  out  1  redirect fetch to jump_target (combinational)
- jump_target  out  8  instr_in[11:4]
- id_valid  out  1  ID/EX entry valid
- id_pc  out  8  PC of the ID/EX entry
- id_opcode  out  4  opcode
- id_rd  out  4  destination register
- id_rs1  out  4  source register 1
- id_rs2  out  4  source register 2
- id_imm  out  8  immediate (zero-extended imm8, or sign-extended 4-bit offset)
- id_reg_write  out  1  writes rd
- id_mem_read  out  1  load
- id_mem_write  out  1  store
- id_is_branch  out  1  BEQ
- id_halt  out  1  HALT entry
- id_illegal  out  1  reserved opcode, treated as NOP
- halted  out  1  HALT has passed decode
- instr_count  out  16  instructions decoded into ID/EX (saturating)
- stall_count  out  16  hazard stall cycles (saturating)

Behaviour:
- Opcode map, op = instr[15:12]:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: rd=[11:8], rs1=[7:4], rs2=[3:0]
  - 6 ADDI: rd=rs1=[11:8], imm=[7:0]
  - 7 LD: rd=[11:8], rs1=[7:4]
  - 8 ST: rs1=[7:4] (address), rs2=[3:0] (data)
  - 9 BEQ: rs1=[11:8], rs2=[7:4], imm=sext([3:0])
  - A JMP: target=[11:4]
  - B-E reserved
  - F HALT
- Register reads (for hazard checks):
  - ALU ops read rs1 and rs2; ADDI reads rs1; LD reads rs1; ST and BEQ read rs1 and rs2.
  - NOP, JMP, HALT and reserved opcodes read nothing.
- Control outputs:
  - reg_write is 1 for opcodes 1-7.
  - For fields an opcode does not use, the registered values are 0.
- Effective valid: eff_v = valid_in & ~flush_in & ~shadow & ~halted.
- Load-use hazard:
  - Condition: haz = eff_v & id_valid & id_mem_read & (decoded instruction reads id_rd).
  - stall = haz.
  - During a hazard the ID/EX register loads a bubble (id_valid=0, all controls 0). The next cycle re-evaluates with the held instruction; the stall lasts exactly 1 cycle.
- Jump:
  - jump = eff_v & ~haz & (op==A); jump_target = instr_in[11:4].
  - JMP is consumed in decode: ID/EX loads a bubble.
  - The shadow register is set for 1 cycle so the instruction following JMP is dropped.
- Flush: flush_in forces a bubble into ID/EX, clears shadow, and suppresses jump and stall.
- HALT: passes to ID/EX with id_halt=1 and sets halted. While halted, every later instruction loads as a bubble until reset.
- Reserved opcodes: loaded with id_illegal=1, id_valid=1 and all controls 0.
- Priority: reset > flush_in > haz > normal load.
- Latency: 1 cycle from instr_in to the ID/EX outputs.
- Counters:
  - instr_count increments on every valid ID/EX load; stall_count increments on every haz cycle.
  - Both saturate at 0xFFFF.
- Reset: all outputs and internal registers are 0 (including id_valid, halted, shadow and both counters). A reset mid-stall or mid-shadow clears everything immediately.

Decomposition:
- Package isa_pkg:
  - opcode localparams (OP_NOP … OP_HALT)
  - field bit positions
  - a function reads_rs1/reads_rs2(op)
  - a control-bundle struct or typedef
- Sub-module hazard_detect: combinational; inputs id_valid, id_mem_read, id_rd, decoded reads and indices; output haz.
- The ID/EX register, shadow flag, halt latch and counters stay in decode_stage.

Test Plan:
- Issue ADD r1,r2,r3 (0x1123, pc 0x05) -> next cycle id_valid=1, id_rd=1, id_rs1=2, id_rs2=3, id_reg_write=1, instr_count=1.
- Issue LD r4,r2 (0x7420), then ADD r5,r4,r1 (0x1541) -> stall=1 for one cycle, one bubble, then the ADD loads; stall_count=1.
- Issue JMP 0x40 (0xA400), then 0x1123 -> jump=1 with jump_target=0x40, ID/EX bubble, the following 0x1123 dropped, instr_count unchanged.
- Issue BEQ r1,r2,-2 (0x912E) -> id_is_branch=1, id_imm=0xFE. Assert flush_in with the next valid instruction -> id_valid=0.
- Issue HALT (0xF000), then 0x1123 -> id_halt=1, halted=1, ADD never loads. Assert reset -> halted=0, all outputs 0.
- Issue reserved 0xC123 -> id_illegal=1, id_reg_write=0. Preset stall_count near 0xFFFF and force hazards -> stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA constants, control bundle and the combinational field decoder shared by
// the decode stage and its hazard logic.
package isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int FA_HI  = 11;
    localparam int FA_LO  = 8;
    localparam int FB_HI  = 7;
    localparam int FB_LO  = 4;
    localparam int FC_HI  = 3;
    localparam int FC_LO  = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic is_branch;
        logic halt;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] imm;
        ctrl_t      ctrl;
    } dec_t;

    function automatic logic reads_rs1(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_BEQ);
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_ST) || (op == OP_BEQ);
    endfunction

    // Fields an opcode does not use are left at zero.
    function automatic dec_t decode(input logic [15:0] instr);
        dec_t d;
        logic [3:0] fa, fb, fc;
        d        = '0;
        fa       = instr[FA_HI:FA_LO];
        fb       = instr[FB_HI:FB_LO];
        fc       = instr[FC_HI:FC_LO];
        d.opcode = instr[OP_HI:OP_LO];
        case (d.opcode)
            OP_NOP, OP_JMP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                d.rd             = fa;
                d.rs1            = fb;
                d.rs2            = fc;
                d.ctrl.reg_write = 1'b1;
            end
            OP_ADDI: begin
                d.rd             = fa;
                d.rs1            = fa;
                d.imm            = instr[FB_HI:FC_LO];
                d.ctrl.reg_write = 1'b1;
            end
            OP_LD: begin
                d.rd             = fa;
                d.rs1            = fb;
                d.ctrl.reg_write = 1'b1;
                d.ctrl.mem_read  = 1'b1;
            end
            OP_ST: begin
                d.rs1            = fb;
                d.rs2            = fc;
                d.ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                d.rs1            = fa;
                d.rs2            = fb;
                d.imm            = {{4{fc[3]}}, fc};
                d.ctrl.is_branch = 1'b1;
            end
            OP_HALT: d.ctrl.halt = 1'b1;
            default: d.ctrl.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: the instruction in decode reads the register that
// the load currently in ID/EX has not yet produced.
module hazard_detect
    import isa_pkg::*;
#(
    parameter int RIW = 4
) (
    input  logic           req_valid,
    input  logic           id_valid,
    input  logic           id_mem_read,
    input  logic [RIW-1:0] id_rd,
    input  logic           use_rs1,
    input  logic           use_rs2,
    input  logic [RIW-1:0] rs1,
    input  logic [RIW-1:0] rs2,
    output logic           haz
);

    logic match;

    assign match = (use_rs1 && (rs1 == id_rd)) || (use_rs2 && (rs2 == id_rd));
    assign haz   = req_valid && id_valid && id_mem_read && match;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field split into the ID/EX register, early JMP resolution,
// load-use stall, flush, HALT latch and saturating performance counters.
module decode_stage
    import isa_pkg::*;
#(
    parameter int IW   = 16,
    parameter int PCW  = 8,
    parameter int RIW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IW-1:0]   instr_in,
    input  logic [PCW-1:0]  pc_in,
    input  logic            valid_in,
    input  logic            flush_in,
    output logic            stall,
    output logic            jump,
    output logic [PCW-1:0]  jump_target,
    output logic            id_valid,
    output logic [PCW-1:0]  id_pc,
    output logic [3:0]      id_opcode,
    output logic [RIW-1:0]  id_rd,
    output logic [RIW-1:0]  id_rs1,
    output logic [RIW-1:0]  id_rs2,
    output logic [7:0]      id_imm,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_is_branch,
    output logic            id_halt,
    output logic            id_illegal,
    output logic            halted,
    output logic [CNTW-1:0] instr_count,
    output logic [CNTW-1:0] stall_count
);

    dec_t dec;
    logic shadow;
    logic eff_v;
    logic haz;
    logic load_v;

    assign dec   = decode(instr_in);
    assign eff_v = valid_in && !flush_in && !shadow && !halted;

    hazard_detect #(.RIW(RIW)) u_haz (
        .req_valid   (eff_v),
        .id_valid    (id_valid),
        .id_mem_read (id_mem_read),
        .id_rd       (id_rd),
        .use_rs1     (reads_rs1(dec.opcode)),
        .use_rs2     (reads_rs2(dec.opcode)),
        .rs1         (dec.rs1),
        .rs2         (dec.rs2),
        .haz         (haz)
    );

    assign stall       = haz;
    assign jump        = eff_v && !haz && (dec.opcode == OP_JMP);
    assign jump_target = instr_in[FA_HI:FB_LO];
    // JMP is fully handled here, so it never occupies ID/EX.
    assign load_v      = eff_v && !haz && (dec.opcode != OP_JMP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow       <= 1'b0;
            halted       <= 1'b0;
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_opcode    <= '0;
            id_rd        <= '0;
            id_rs1       <= '0;
            id_rs2       <= '0;
            id_imm       <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_is_branch <= 1'b0;
            id_halt      <= 1'b0;
            id_illegal   <= 1'b0;
            instr_count  <= '0;
            stall_count  <= '0;
        end else begin
            // The fetch after a JMP is already in flight; drop exactly that one.
            shadow <= jump;
            if (load_v && (dec.opcode == OP_HALT))
                halted <= 1'b1;

            if (load_v) begin
                id_valid     <= 1'b1;
                id_pc        <= pc_in;
                id_opcode    <= dec.opcode;
                id_rd        <= dec.rd;
                id_rs1       <= dec.rs1;
                id_rs2       <= dec.rs2;
                id_imm       <= dec.imm;
                id_reg_write <= dec.ctrl.reg_write;
                id_mem_read  <= dec.ctrl.mem_read;
                id_mem_write <= dec.ctrl.mem_write;
                id_is_branch <= dec.ctrl.is_branch;
                id_halt      <= dec.ctrl.halt;
                id_illegal   <= dec.ctrl.illegal;
            end else begin
                id_valid     <= 1'b0;
                id_pc        <= '0;
                id_opcode    <= '0;
                id_rd        <= '0;
                id_rs1       <= '0;
                id_rs2       <= '0;
                id_imm       <= '0;
                id_reg_write <= 1'b0;
                id_mem_read  <= 1'b0;
                id_mem_write <= 1'b0;
                id_is_branch <= 1'b0;
                id_halt      <= 1'b0;
                id_illegal   <= 1'b0;
            end

            if (load_v && (instr_count != {CNTW{1'b1}}))
                instr_count <= instr_count + 1'b1;
            if (haz && (stall_count != {CNTW{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage; a second instance with 4-bit counters
// exercises counter saturation within a short run.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [7:0]  pc;
    logic        valid, flush;

    logic        stall, jump, id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic        id_is_branch, id_halt, id_illegal, halted;
    logic [7:0]  jump_target, id_pc, id_imm;
    logic [3:0]  id_opcode, id_rd, id_rs1, id_rs2;
    logic [15:0] instr_count, stall_count;

    logic        s_stall, s_jump, s_id_valid, s_id_reg_write, s_id_mem_read, s_id_mem_write;
    logic        s_id_is_branch, s_id_halt, s_id_illegal, s_halted;
    logic [7:0]  s_jump_target, s_id_pc, s_id_imm;
    logic [3:0]  s_id_opcode, s_id_rd, s_id_rs1, s_id_rs2;
    logic [3:0]  s_instr_count, s_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .instr_in(instr), .pc_in(pc), .valid_in(valid),
        .flush_in(flush), .stall(stall), .jump(jump), .jump_target(jump_target),
        .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_is_branch(id_is_branch),
        .id_halt(id_halt), .id_illegal(id_illegal), .halted(halted),
        .instr_count(instr_count), .stall_count(stall_count)
    );

    decode_stage #(.CNTW(4)) dut_sat (
        .clk(clk), .reset(reset), .instr_in(instr), .pc_in(pc), .valid_in(valid),
        .flush_in(flush), .stall(s_stall), .jump(s_jump), .jump_target(s_jump_target),
        .id_valid(s_id_valid), .id_pc(s_id_pc), .id_opcode(s_id_opcode), .id_rd(s_id_rd),
        .id_rs1(s_id_rs1), .id_rs2(s_id_rs2), .id_imm(s_id_imm), .id_reg_write(s_id_reg_write),
        .id_mem_read(s_id_mem_read), .id_mem_write(s_id_mem_write), .id_is_branch(s_id_is_branch),
        .id_halt(s_id_halt), .id_illegal(s_id_illegal), .halted(s_halted),
        .instr_count(s_instr_count), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] i, input logic [7:0] p, input logic v, input logic f);
        instr = i;
        pc    = p;
        valid = v;
        flush = f;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(16'h0000, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_id_valid", id_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_opcode", id_opcode, 0);
        reset = 1'b0;

        // ADD r1,r2,r3
        drive(16'h1123, 8'h05, 1'b1, 1'b0);
        chk("add_no_stall", stall, 0);
        tick();
        chk("add_valid", id_valid, 1);
        chk("add_pc", id_pc, 8'h05);
        chk("add_opcode", id_opcode, 4'h1);
        chk("add_rd", id_rd, 1);
        chk("add_rs1", id_rs1, 2);
        chk("add_rs2", id_rs2, 3);
        chk("add_reg_write", id_reg_write, 1);
        chk("add_count", instr_count, 1);

        // LD r4,r2 then dependent ADD r5,r4,r1
        drive(16'h7420, 8'h06, 1'b1, 1'b0);
        chk("ld_no_stall", stall, 0);
        tick();
        chk("ld_mem_read", id_mem_read, 1);
        chk("ld_rd", id_rd, 4);
        chk("ld_rs1", id_rs1, 2);
        chk("ld_rs2_zero", id_rs2, 0);
        drive(16'h1541, 8'h07, 1'b1, 1'b0);
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bubble", id_valid, 0);
        chk("lu_bubble_rw", id_reg_write, 0);
        chk("lu_stall_count", stall_count, 1);
        chk("lu_count_held", instr_count, 2);
        chk("lu_stall_one_cycle", stall, 0);
        tick();
        chk("lu_add_valid", id_valid, 1);
        chk("lu_add_rd", id_rd, 5);
        chk("lu_add_rs1", id_rs1, 4);
        chk("lu_add_rs2", id_rs2, 1);
        chk("lu_add_count", instr_count, 3);

        // JMP 0x40 then shadowed ADD
        drive(16'hA400, 8'h08, 1'b1, 1'b0);
        chk("jmp_jump", jump, 1);
        chk("jmp_target", jump_target, 8'h40);
        tick();
        chk("jmp_bubble", id_valid, 0);
        drive(16'h1123, 8'h40, 1'b1, 1'b0);
        chk("shadow_no_jump", jump, 0);
        tick();
        chk("shadow_dropped", id_valid, 0);
        chk("shadow_count", instr_count, 3);

        // BEQ r1,r2,-2
        drive(16'h912E, 8'h41, 1'b1, 1'b0);
        tick();
        chk("beq_branch", id_is_branch, 1);
        chk("beq_imm", id_imm, 8'hFE);
        chk("beq_rs1", id_rs1, 1);
        chk("beq_rs2", id_rs2, 2);
        chk("beq_rd_zero", id_rd, 0);
        chk("beq_rw", id_reg_write, 0);
        chk("beq_count", instr_count, 4);
        drive(16'h1123, 8'h42, 1'b1, 1'b1);
        tick();
        chk("flush_bubble", id_valid, 0);
        chk("flush_count", instr_count, 4);

        // Flushed JMP: no redirect, no shadow
        drive(16'hA400, 8'h43, 1'b1, 1'b1);
        chk("flush_jmp_suppressed", jump, 0);
        tick();
        drive(16'h1123, 8'h44, 1'b1, 1'b0);
        tick();
        chk("post_flush_jmp_load", id_valid, 1);
        chk("post_flush_jmp_count", instr_count, 5);

        // Flush also suppresses a would-be load-use stall
        drive(16'h7420, 8'h45, 1'b1, 1'b0);
        tick();
        drive(16'h1541, 8'h46, 1'b1, 1'b1);
        chk("flush_no_stall", stall, 0);
        tick();
        chk("flush_stall_count", stall_count, 1);
        chk("flush_ld_count", instr_count, 6);

        // Reserved opcode, then ADDI
        drive(16'hC123, 8'h47, 1'b1, 1'b0);
        tick();
        chk("rsv_valid", id_valid, 1);
        chk("rsv_illegal", id_illegal, 1);
        chk("rsv_rw", id_reg_write, 0);
        chk("rsv_rd", id_rd, 0);
        chk("rsv_opcode", id_opcode, 4'hC);
        drive(16'h6A05, 8'h48, 1'b1, 1'b0);
        tick();
        chk("addi_rd", id_rd, 4'hA);
        chk("addi_rs1", id_rs1, 4'hA);
        chk("addi_imm", id_imm, 8'h05);
        chk("addi_illegal_clr", id_illegal, 0);
        chk("addi_count", instr_count, 8);

        // HALT then ADD
        drive(16'hF000, 8'h49, 1'b1, 1'b0);
        tick();
        chk("halt_id_halt", id_halt, 1);
        chk("halt_valid", id_valid, 1);
        chk("halt_halted", halted, 1);
        chk("halt_count", instr_count, 9);
        drive(16'h1123, 8'h4A, 1'b1, 1'b0);
        tick();
        chk("halted_drop", id_valid, 0);
        chk("halted_sticky", halted, 1);
        chk("halted_count", instr_count, 9);

        // Asynchronous reset mid-run
        reset = 1'b1;
        #1;
        chk("rst2_halted", halted, 0);
        chk("rst2_id_halt", id_halt, 0);
        chk("rst2_instr_count", instr_count, 0);
        chk("rst2_stall_count", stall_count, 0);
        tick();
        reset = 1'b0;
        drive(16'h0000, 8'h00, 1'b0, 1'b0);
        tick();

        // 17 hazards: 4-bit counters saturate, 16-bit ones keep counting
        for (int k = 0; k < 17; k++) begin
            drive(16'h7420, 8'h10, 1'b1, 1'b0);
            tick();
            drive(16'h1541, 8'h11, 1'b1, 1'b0);
            tick();
            tick();
        end
        drive(16'h0000, 8'h00, 1'b0, 1'b0);
        tick();
        chk("sat_stall_small", s_stall_count, 4'hF);
        chk("sat_instr_small", s_instr_count, 4'hF);
        chk("sat_stall_main", stall_count, 17);
        chk("sat_instr_main", instr_count, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
